// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The controller holds the master modport and the subtractor holds the slave modport.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;  // request, sampled only while busy=0
  logic [WIDTH-1:0] a;      // minuend
  logic [WIDTH-1:0] b;      // subtrahend
  logic             bi;     // borrow-in
  logic             busy;   // high while bits are being computed
  logic             done;   // one-cycle pulse: d/bo valid
  logic [WIDTH-1:0] d;      // difference, held until next completion
  logic             bo;     // final borrow-out, held with d

  modport master (
    output start,
    output a,
    output b,
    output bi,
    input  busy,
    input  done,
    input  d,
    input  bo
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bi,
    output busy,
    output done,
    output d,
    output bo
  );

endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - BI, one bit per clock, LSB first.
// A single 1-bit full-subtractor cell feeds a borrow register. Operands are latched on the
// accepted start and shifted right. The difference bits shift in at the MSB end of a
// partial-result register.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);

  // Counter sized to hold 0..WIDTH.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bo;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_a0;
  logic             w_b0;
  logic             w_diff;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_full;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign w_a0      = r_a[0];
  assign w_b0      = r_b[0];
  assign w_diff    = w_a0 ^ w_b0 ^ r_br;
  assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);

  assign w_shift = (r_state == StRun);
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // The partial-result register holds only WIDTH-1 bits. The final bit goes straight
  // into d, together with the stored bits, so d is already valid during the done cycle.
  if (WIDTH == 1) begin : g_res_w1
    assign w_res_full = w_diff;
  end else begin : g_res_wn
    logic [WIDTH-2:0] r_res;

    // Partial-result shift register: newest difference bit enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= '0;
      end else if (w_accept) begin
        r_res <= '0;
      end else if (w_shift) begin
        r_res <= w_res_full[WIDTH-1:1];
      end
    end

    assign w_res_full = {w_diff, r_res};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode. DONE accepts a new start just like IDLE does.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Operand shift registers, borrow and bit counter. Operands are sampled only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_br  <= bus.bi;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result outputs update only on the last RUN edge, so they are valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d  <= '0;
      r_bo <= 1'b0;
    end else if (w_shift && w_last) begin
      r_d  <= w_res_full;
      r_bo <= w_br_next;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.d    = r_d;
  assign bus.bo   = r_bo;

  // Handshake sanity: never busy and done together; done never lasts two cycles.
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_busy && w_done));
  a_done_single : assert property (@(posedge clk) disable iff (!rst_n)
    w_done |=> !w_done);

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub. Stimulus pushes the expected {bo, d} of each accepted
// operation. Per-DUT monitors pop and compare on every done pulse. They also check busy
// length, done width and that d/bo hold between completions.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(1)) if1 ();

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q8[$];  // expected {bo, d} for the 8-bit DUT
  logic [1:0] q1[$];  // expected {bo, d} for the 1-bit DUT

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  // Hand-computed vectors: a, b, bi, d, bo.
  localparam vec_t VECS [10] = '{
    '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0},
    '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0},
    '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
    '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0},
    '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0},
    '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1}
  };

  // 1-bit table indexed by {a, b, bi}; entries are {bo, d}.
  localparam logic [1:0] W1_EXP [8] = '{
    2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11
  };

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'b0, bi};
  endfunction

  // Issue one op when the DUT can accept; called at a negedge, returns at a negedge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [8:0] exp);
    int t = 0;
    while (if8.busy !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (if8.busy !== 1'b0) begin
      chk("issue8_wait_idle", {63'b0, if8.busy}, 64'd0);
      return;
    end
    if8.a     = a;
    if8.b     = b;
    if8.bi    = bi;
    if8.start = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    // Scramble the operands mid-run; they must have no effect.
    if8.start = 1'b0;
    if8.a     = ~a;
    if8.b     = ~b;
    if8.bi    = ~bi;
  endtask

  task automatic issue1(input logic a, input logic b, input logic bi, input logic [1:0] exp);
    int t = 0;
    while (if1.busy !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (if1.busy !== 1'b0) begin
      chk("issue1_wait_idle", {63'b0, if1.busy}, 64'd0);
      return;
    end
    if1.a     = a;
    if1.b     = b;
    if1.bi    = bi;
    if1.start = 1'b1;
    q1.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    if1.a     = ~a;
    if1.b     = ~b;
    if1.bi    = ~bi;
  endtask

  // Monitor for the 8-bit DUT.
  logic       prev_done8 = 1'b0;
  logic [7:0] last_d8    = 8'h00;
  logic       last_bo8   = 1'b0;
  int         busy_run8  = 0;
  logic [8:0] e8;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done8 = 1'b0;
      last_d8    = 8'h00;
      last_bo8   = 1'b0;
      busy_run8  = 0;
    end else begin
      if (if8.busy === 1'b1) busy_run8++;
      if (if8.done === 1'b1) begin
        chk("done8_width", {63'b0, prev_done8}, 64'd0);
        if (q8.size() == 0) begin
          chk("done8_unexpected", {63'b0, if8.done}, 64'd0);
        end else begin
          e8 = q8.pop_front();
          chk("result8", {55'b0, if8.bo, if8.d}, {55'b0, e8});
          chk("busy8_cycles", 64'(busy_run8), 64'd8);
        end
        busy_run8 = 0;
        last_d8   = if8.d;
        last_bo8  = if8.bo;
      end else begin
        chk("hold8", {55'b0, if8.bo, if8.d}, {55'b0, last_bo8, last_d8});
      end
      prev_done8 = if8.done;
    end
  end

  // Monitor for the 1-bit DUT.
  logic       prev_done1 = 1'b0;
  logic       last_d1    = 1'b0;
  logic       last_bo1   = 1'b0;
  int         busy_run1  = 0;
  logic [1:0] e1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done1 = 1'b0;
      last_d1    = 1'b0;
      last_bo1   = 1'b0;
      busy_run1  = 0;
    end else begin
      if (if1.busy === 1'b1) busy_run1++;
      if (if1.done === 1'b1) begin
        chk("done1_width", {63'b0, prev_done1}, 64'd0);
        if (q1.size() == 0) begin
          chk("done1_unexpected", {63'b0, if1.done}, 64'd0);
        end else begin
          e1 = q1.pop_front();
          chk("result1", {62'b0, if1.bo, if1.d}, {62'b0, e1});
          chk("busy1_cycles", 64'(busy_run1), 64'd1);
        end
        busy_run1 = 0;
        last_d1   = if1.d;
        last_bo1  = if1.bo;
      end else begin
        chk("hold1", {62'b0, if1.bo, if1.d}, {62'b0, last_bo1, last_d1});
      end
      prev_done1 = if1.done;
    end
  end

  // Watchdog: a hung run still reports and stops.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] va;
  logic [7:0] vb;
  logic       vbi;
  logic [2:0] idx;
  int         last_acc;
  int         t;

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bi = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bi = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, if8.busy}, 64'd0);
    chk("reset_done", {63'b0, if8.done}, 64'd0);
    chk("reset_d",    {56'b0, if8.d},    64'd0);
    chk("reset_bo",   {63'b0, if8.bo},   64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back (later ones accepted from DONE).
    for (int i = 0; i < 10; i++) begin
      issue8(VECS[i].a, VECS[i].b, VECS[i].bi, {VECS[i].bo, VECS[i].d});
    end

    // start held high with fresh operands every cycle: only accept edges count.
    last_acc  = -1;
    if8.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      va  = 8'(c * 37 + 11);
      vb  = 8'(c * 53 + 5);
      vbi = c[0];
      if8.a  = va;
      if8.b  = vb;
      if8.bi = vbi;
      if (if8.busy === 1'b0) begin
        q8.push_back(model8(va, vb, vbi));
        if (last_acc >= 0) chk("accept_spacing", 64'(c - last_acc), 64'd9);
        last_acc = c;
      end
      @(negedge clk);
    end
    if8.start = 1'b0;

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      va  = 8'($urandom);
      vb  = 8'($urandom);
      vbi = 1'($urandom);
      issue8(va, vb, vbi, model8(va, vb, vbi));
    end

    // Leave nonzero d/bo so the reset clearing is visible.
    issue8(8'h01, 8'h40, 1'b0, {1'b1, 8'hC1});

    // Asynchronous reset in RUN cycle 4.
    issue8(8'h33, 8'h11, 1'b0, {1'b0, 8'h22});
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, if8.busy}, 64'd0);
    chk("async_rst_done", {63'b0, if8.done}, 64'd0);
    chk("async_rst_d",    {56'b0, if8.d},    64'd0);
    chk("async_rst_bo",   {63'b0, if8.bo},   64'd0);
    q8.delete();
    q1.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", {63'b0, if8.busy}, 64'd0);

    // Fresh op after the abort.
    issue8(8'h33, 8'h11, 1'b0, {1'b0, 8'h22});
    issue8(8'h05, 8'h03, 1'b0, {1'b0, 8'h02});

    // WIDTH=1: every operand combination.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      issue1(idx[2], idx[1], idx[0], W1_EXP[i]);
    end

    // Drain both scoreboards.
    t = 0;
    while ((q8.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q8", 64'(q8.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
